// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  localparam int ADDR_W_D = 6;
  localparam int DATA_W_D = 8;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response bus plus side-band loader port of the memory responder.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
);

  logic              rd_mem;
  logic              wr_mem;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output rd_mem, wr_mem, addr, wdata, ld_en, ld_addr, ld_data,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  rd_mem, wr_mem, addr, wdata, ld_en, ld_addr, ld_data,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read register holds its value until the next read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Storage is never reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data register, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts CPU read/write requests, inserts wait states,
// then answers with a one-cycle ready pulse. Loader writes take priority in IDLE.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_D,
  parameter int DATA_W      = DATA_W_D,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic              ld_fire;
  logic              accept;
  logic              commit;
  logic              op_wr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state logic, wait counter and request latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    ld_fire = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld_en) begin
          ld_fire = 1'b1;
        end else if (bus.rd_mem || bus.wr_mem) begin
          accept  = 1'b1;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wr_d    = bus.wr_mem;
          err_d   = bus.rd_mem && bus.wr_mem;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port muxing. With zero wait states the RESP-entry edge is the
  // accept edge itself, so the live bus values are used instead of the latches.
  always_comb begin
    op_wr     = (state_q == IDLE) ? bus.wr_mem : wr_q;
    op_addr   = (state_q == IDLE) ? bus.addr   : addr_q;
    op_wdata  = (state_q == IDLE) ? bus.wdata  : wdata_q;
    commit    = (state_d == RESP) && (state_q != RESP);
    mem_we    = ld_fire || (commit && op_wr);
    mem_waddr = ld_fire ? bus.ld_addr : op_addr;
    mem_wdata = ld_fire ? bus.ld_data : op_wdata;
    mem_re    = commit && !op_wr;
  end

  // State, counter and latch registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (op_addr),
    .rdata (mem_rdata)
  );

  assign bus.ready = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.err   = err_q;
  assign bus.rdata = mem_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: main instance with one wait state, plus
// zero- and three-wait-state instances for latency checks.
module tb_mem_responder;

  typedef struct packed {
    logic       is_rd;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(6), .DATA_W(8)) b1 ();
  mem_responder_if #(.ADDR_W(6), .DATA_W(8)) b0 ();
  mem_responder_if #(.ADDR_W(6), .DATA_W(8)) b3 ();

  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(1))
    dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3))
    dut3 (.clk(clk), .reset(reset), .bus(b3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse of the main instance pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && b1.ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("busy_at_ready", 32'(b1.busy), 32'd1);
        if (e.is_rd) check("rdata", 32'(b1.rdata), 32'(e.data));
      end
    end
  end

  // Load the same word into all three instances (all must be idle). Called at a negedge.
  task automatic ld_all(input logic [5:0] a, input logic [7:0] d);
    b1.ld_en = 1'b1; b1.ld_addr = a; b1.ld_data = d;
    b0.ld_en = 1'b1; b0.ld_addr = a; b0.ld_data = d;
    b3.ld_en = 1'b1; b3.ld_addr = a; b3.ld_data = d;
    @(negedge clk);
    b1.ld_en = 1'b0; b0.ld_en = 1'b0; b3.ld_en = 1'b0;
  endtask

  // One CPU transaction on the main instance. Called at a negedge.
  task automatic op1(input logic rd, input logic wr, input logic [5:0] a,
                     input logic [7:0] d, input logic [7:0] exp,
                     input int exp_err, input bit ld_in_wait);
    exp_t ent;
    int lat, nbusy, nerr;
    bit got;
    ent.is_rd = rd & ~wr;
    ent.data  = exp;
    sb.push_back(ent);
    b1.rd_mem = rd; b1.wr_mem = wr; b1.addr = a; b1.wdata = d;
    lat = 0; nbusy = 0; nerr = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (b1.busy === 1'b1) nbusy++;
      if (b1.err === 1'b1) nerr++;
      if (ld_in_wait && lat == 1) begin
        b1.ld_en = 1'b1; b1.ld_addr = 6'd12; b1.ld_data = 8'hEE;
      end
      if (b1.ready === 1'b1) got = 1'b1;
    end
    b1.rd_mem = 1'b0; b1.wr_mem = 1'b0; b1.ld_en = 1'b0;
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'd2);
    check("busy_cycles", 32'(nbusy), 32'd2);
    check("err_pulses", 32'(nerr), 32'(exp_err));
    @(negedge clk);
    check("ready_width", 32'(b1.ready), 32'd0);
    check("busy_after", 32'(b1.busy), 32'd0);
  endtask

  // Same request to the zero- and three-wait-state instances. Called at a negedge.
  task automatic op03(input logic rd, input logic wr, input logic [5:0] a,
                      input logic [7:0] d, input logic [7:0] exp);
    int lat0, lat3, r0, r3;
    logic [7:0] rd0, rd3;
    b0.rd_mem = rd; b0.wr_mem = wr; b0.addr = a; b0.wdata = d;
    b3.rd_mem = rd; b3.wr_mem = wr; b3.addr = a; b3.wdata = d;
    lat0 = 0; lat3 = 0; r0 = 0; r3 = 0; rd0 = '0; rd3 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b0.ready === 1'b1) begin
        r0++; if (lat0 == 0) lat0 = i; rd0 = b0.rdata;
        b0.rd_mem = 1'b0; b0.wr_mem = 1'b0;
      end
      if (b3.ready === 1'b1) begin
        r3++; if (lat3 == 0) lat3 = i; rd3 = b3.rdata;
        b3.rd_mem = 1'b0; b3.wr_mem = 1'b0;
      end
    end
    b0.rd_mem = 1'b0; b0.wr_mem = 1'b0; b3.rd_mem = 1'b0; b3.wr_mem = 1'b0;
    check("w0_latency", 32'(lat0), 32'd1);
    check("w3_latency", 32'(lat3), 32'd4);
    check("w0_ready_count", 32'(r0), 32'd1);
    check("w3_ready_count", 32'(r3), 32'd1);
    if (rd && !wr) begin
      check("w0_rdata", 32'(rd0), 32'(exp));
      check("w3_rdata", 32'(rd3), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.rd_mem = 0; b1.wr_mem = 0; b1.addr = '0; b1.wdata = '0;
    b1.ld_en = 0; b1.ld_addr = '0; b1.ld_data = '0;
    b0.rd_mem = 0; b0.wr_mem = 0; b0.addr = '0; b0.wdata = '0;
    b0.ld_en = 0; b0.ld_addr = '0; b0.ld_data = '0;
    b3.rd_mem = 0; b3.wr_mem = 0; b3.addr = '0; b3.wdata = '0;
    b3.ld_en = 0; b3.ld_addr = '0; b3.ld_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(b1.ready), 32'd0);
    check("rst_busy",  32'(b1.busy),  32'd0);
    check("rst_err",   32'(b1.err),   32'd0);
    check("rst_rdata", 32'(b1.rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: load then read
    ld_all(6'd5, 8'h3C);
    op1(1'b1, 1'b0, 6'd5, 8'h00, 8'h3C, 0, 1'b0);

    // 2: write then read at the top address
    op1(1'b0, 1'b1, 6'h3F, 8'hA5, 8'h00, 0, 1'b0);
    op1(1'b1, 1'b0, 6'h3F, 8'h00, 8'hA5, 0, 1'b0);

    // 3: latency of zero and three wait states, including a zero-wait write
    ld_all(6'd1, 8'h96);
    op03(1'b1, 1'b0, 6'd1, 8'h00, 8'h96);
    op03(1'b0, 1'b1, 6'h20, 8'h5C, 8'h00);
    op03(1'b1, 1'b0, 6'h20, 8'h00, 8'h5C);

    // 4: rd/wr conflict executes as a write with an err pulse
    op1(1'b1, 1'b1, 6'd2, 8'h11, 8'h00, 1, 1'b0);
    op1(1'b1, 1'b0, 6'd2, 8'h00, 8'h11, 0, 1'b0);

    // 5a: loader wins over a simultaneous read, read follows
    b1.ld_en = 1'b1; b1.ld_addr = 6'd7; b1.ld_data = 8'h5A;
    b1.rd_mem = 1'b1; b1.addr = 6'd7;
    @(negedge clk);
    check("ld_priority_busy", 32'(b1.busy), 32'd0);
    b1.ld_en = 1'b0;
    op1(1'b1, 1'b0, 6'd7, 8'h00, 8'h5A, 0, 1'b0);

    // 5b: loader strobe during WAIT is dropped
    ld_all(6'd12, 8'h44);
    op1(1'b1, 1'b0, 6'd5, 8'h00, 8'h3C, 0, 1'b1);
    op1(1'b1, 1'b0, 6'd12, 8'h00, 8'h44, 0, 1'b0);

    // 6: reset during WAIT of a write leaves RAM untouched
    ld_all(6'd9, 8'h22);
    b1.wr_mem = 1'b1; b1.addr = 6'd9; b1.wdata = 8'h77;
    @(negedge clk);
    check("t6_busy_in_wait", 32'(b1.busy), 32'd1);
    check("t6_rdata_before", 32'(b1.rdata), 32'h44);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_ready", 32'(b1.ready), 32'd0);
    check("t6_rst_busy",  32'(b1.busy),  32'd0);
    check("t6_rst_err",   32'(b1.err),   32'd0);
    check("t6_rst_rdata", 32'(b1.rdata), 32'd0);
    b1.wr_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op1(1'b1, 1'b0, 6'd9, 8'h00, 8'h22, 0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
